// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: state encoding,
// default sizing and the pointer-width helper.
package fifo_arb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int DWIDTH_DEF   = 8;
    localparam int MAXBURST_DEF = 4;
    localparam int BCNTW_DEF    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Pointer width for n requesters; never below one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search. The search starts one
// past the previous owner and wraps modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan last+1 .. last+NREQ; the first requester hit is the winner.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                found        = 1'b1;
                win_idx      = idx;
                win[idx]     = 1'b1;
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the FIFO write port among
// NREQ requesters. Define FIFO_ARB_BURST_EN to hold a grant for up to
// MAXBURST beats; without it every accepted beat re-arbitrates.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int MAXBURST = MAXBURST_DEF,
    parameter int BCNTW    = BCNTW_DEF
) (
    input  logic                   wclk,
    input  logic                   reset_L,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        grant,
    output logic                   push,
    output logic [DWIDTH-1:0]      wdata,
    input  logic                   full
);

    localparam int PW = clog2(NREQ);

    arb_state_e     state;
    logic [PW-1:0]  last;       // index of the current / most recent owner
    logic [NREQ-1:0] pick_win;
    logic [PW-1:0]  pick_idx;
    logic           pick_any;
    logic           own_req;
    logic           burst_end;

    // One picker serves both IDLE entry and burst-end handover: in both
    // cases the search starts just after 'last'.
    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (req),
        .last    (last),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // full gates acceptance directly, so no beat is ever in flight.
    assign ack     = grant & req & {NREQ{~full}};
    assign push    = |ack;
    assign own_req = |(grant & req);
    // While granted, 'last' is the owner index, so it selects the data.
    assign wdata   = (|grant) ? req_data[int'(last)*DWIDTH +: DWIDTH] : '0;

`ifdef FIFO_ARB_BURST_EN
    logic [BCNTW-1:0] bcnt;

    assign burst_end = (bcnt == BCNTW'(MAXBURST - 1));

    // Beat counter: cleared in IDLE and at burst end, so it never wraps.
    always_ff @(posedge wclk) begin
        if (!reset_L)               bcnt <= '0;
        else if (state == ST_IDLE)  bcnt <= '0;
        else if (push)              bcnt <= burst_end ? '0 : bcnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(MAXBURST), 32'(BCNTW)};
    assign burst_end  = 1'b1;
`endif

    // Grant FSM: arbitrate from IDLE, hold for the burst, hand over with
    // no gap at burst end, drop to IDLE when the owner withdraws.
    always_ff @(posedge wclk) begin
        if (!reset_L) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= PW'(NREQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_win;
                        last  <= pick_idx;
                        state <= ST_BURST;
                    end else begin
                        grant <= '0;
                    end
                end
                ST_BURST: begin
                    if (!own_req) begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end else if (push && burst_end) begin
                        if (pick_any) begin
                            grant <= pick_win;
                            last  <= pick_idx;
                        end else begin
                            grant <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against an index-level reference
// model (owner number, beat count, round-robin pointer as plain ints).
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam int MB = MAXB;
`else
    localparam int MB = 1;
`endif

    logic                 wclk = 1'b0;
    logic                 reset_L;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      grant;
    logic                 push;
    logic [DW-1:0]        wdata;
    logic                 full;

    fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAXBURST(MAXB), .BCNTW(3)) dut (
        .wclk     (wclk),
        .reset_L  (reset_L),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant    (grant),
        .push     (push),
        .wdata    (wdata),
        .full     (full)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    int  own    = -1;
    int  beats  = 0;
    int  rr     = NREQ - 1;
    bit  mvalid = 1'b0;

    logic [DW-1:0]   dat [NREQ];
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] last_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input int from, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    task automatic model_edge(input logic [NREQ-1:0] r, input logic f, input logic rst);
        int w;
        if (!rst) begin
            own = -1; beats = 0; rr = NREQ - 1; mvalid = 1'b1;
        end else if (own < 0) begin
            w = pick(rr, r);
            if (w >= 0) begin own = w; rr = w; beats = 0; end
        end else if (!r[own]) begin
            own = -1;
        end else if (!f) begin
            beats++;
            if (beats == MB) begin
                w = pick(rr, r);
                beats = 0;
                if (w >= 0) begin own = w; rr = w; end
                else own = -1;
            end
        end
    endtask

    // One cycle: drive, check settled outputs mid-cycle, clock, advance model.
    task automatic step(input logic [NREQ-1:0] r, input logic f, input logic rst);
        logic [NREQ-1:0] eg, ea;
        logic [DW-1:0]   ed;
        req = r; full = f; reset_L = rst;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dat[i];
        #4;
        eg = (own < 0) ? '0 : (NREQ'(1) << own);
        ea = eg & r & {NREQ{~f}};
        ed = (own < 0) ? '0 : dat[own];
        if (mvalid) begin
            chk("grant", 32'(grant), 32'(eg));
            chk("ack",   32'(ack),   32'(ea));
            chk("push",  32'(push),  32'(|ea));
            chk("wdata", 32'(wdata), 32'(ed));
        end
        last_ack = ea;
        @(posedge wclk);
        model_edge(r, f, rst);
        cyc++;
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        logic f;
        for (int i = 0; i < NREQ; i++) dat[i] = DW'(8'h10 + i);
        pend = '0;
        last_ack = '0;
        req = '0; full = 1'b0; reset_L = 1'b0; req_data = '0;
        @(posedge wclk); #1;

        // reset, then single requester 0 with 0xA5, requester 1 joins
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_push",  32'(push),  32'h0);
        dat[0] = 8'hA5;
        step(4'b0001, 1'b0, 1'b1);
        chk("first_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0011, 1'b0, 1'b1);

        // all requesting: rotation, continuous push
        for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, 1'b1);
        // stall bursts with full
        for (int i = 0; i < 12; i++) step(4'b1111, (i % 5) >= 2, 1'b1);
        // owner drop while another waits
        for (int i = 0; i < 4; i++) step(4'b1010, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b1);
        // lone requester 3 is regranted back to back
        for (int i = 0; i < 10; i++) step(4'b1000, 1'b0, 1'b1);
        // mid-burst reset with owner 3, then 1010 arbitrates to 1 first
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b1);
        step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b1);
        chk("rst_first_grant", 32'(grant), 32'h2);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // randomized requesters honouring hold-until-ack, with random drops
        for (int c = 0; c < 3000; c++) begin
            r = pend;
            f = ($urandom_range(3) == 0);
            step(r, f, 1'b1);
            for (int i = 0; i < NREQ; i++) begin
                if (last_ack[i]) begin
                    pend[i] = ($urandom_range(3) != 0);
                    dat[i]  = DW'($urandom);
                end else if (pend[i]) begin
                    if ($urandom_range(15) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(1) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = DW'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
